// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 32-bit integer ALU for the maxicore32 execute stage.
//
// One operation per cycle, no handshake. Operands are sampled on the rising
// edge of clock; result and the C/Z/N/V flags are registered and valid right
// after that edge. reset (active-low, asynchronous) clears every output.
//
// Ports:
//   clock      in   1   system clock
//   reset      in   1   asynchronous active-low reset
//   op         in   5   operation select
//   reg2       in  32   left operand (sole operand for unary ops)
//   reg3       in  32   right operand
//   carry_in   in   1   carry/borrow in for ADDC/SUBC
//   result     out 32   registered result
//   carry_out  out  1   registered C flag
//   zero_out   out  1   registered Z flag
//   neg_out    out  1   registered N flag
//   over_out   out  1   registered V flag
//
// Build option: define ALU_MULTIPLY_EN to implement MULU (0x09) and
// MULS (0x0A). Without it no multiplier is built and both opcodes behave
// as unassigned (result = reg2, all flags 0).
// ---------------------------------------------------------------------------
module alu (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  op,
    input  logic [31:0] reg2,
    input  logic [31:0] reg3,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        zero_out,
    output logic        neg_out,
    output logic        over_out
);

    localparam logic [4:0] OP_ADD   = 5'h00, OP_ADDC  = 5'h01, OP_SUB  = 5'h02,
                           OP_SUBC  = 5'h03, OP_AND   = 5'h04, OP_OR   = 5'h05,
                           OP_XOR   = 5'h06, OP_COMP  = 5'h07, OP_BIT  = 5'h08,
                           OP_NOT   = 5'h10, OP_LSL   = 5'h11, OP_LSR  = 5'h12,
                           OP_ASL   = 5'h13, OP_ASR   = 5'h14, OP_NEG  = 5'h15,
                           OP_TEST  = 5'h16;
`ifdef ALU_MULTIPLY_EN
    localparam logic [4:0] OP_MULU  = 5'h09, OP_MULS  = 5'h0A;
`endif

    // Signed overflow of a+b: same-sign operands, sum sign differs.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Signed overflow of a-b: operand signs differ, result sign differs from a.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    logic        cin_add, cin_sub;
    logic [32:0] add_sum, sub_diff;
    logic [31:0] res_p0, flag_src_p0;
    logic        c_p0, v_p0, zn_en_p0;
`ifdef ALU_MULTIPLY_EN
    logic        [31:0] mulu_p0;
    logic signed [31:0] mul_a_s, mul_b_s, muls_p0;
`endif

    // Stage p0: combinational operation and flag evaluation
    always_comb begin
        // Carry/borrow in only applies to the "with carry" variants; COMP uses plain SUB.
        cin_add  = (op == OP_ADDC) ? carry_in : 1'b0;
        cin_sub  = (op == OP_SUBC) ? carry_in : 1'b0;
        // 33-bit forms so bit 32 is the carry (add) or borrow (sub).
        add_sum  = {1'b0, reg2} + {1'b0, reg3} + {32'd0, cin_add};
        sub_diff = {1'b0, reg2} - {1'b0, reg3} - {32'd0, cin_sub};
`ifdef ALU_MULTIPLY_EN
        mulu_p0  = {16'd0, reg2[15:0]} * {16'd0, reg3[15:0]};
        mul_a_s  = {{16{reg2[15]}}, reg2[15:0]};
        mul_b_s  = {{16{reg3[15]}}, reg3[15:0]};
        muls_p0  = mul_a_s * mul_b_s;
`endif

        res_p0      = reg2;
        c_p0        = 1'b0;
        v_p0        = 1'b0;
        zn_en_p0    = 1'b1;
        flag_src_p0 = 32'd0;

        unique case (op)
            OP_ADD, OP_ADDC: begin
                res_p0 = add_sum[31:0];
                c_p0   = add_sum[32];
                v_p0   = add_ovf(reg2[31], reg3[31], add_sum[31]);
            end
            OP_SUB, OP_SUBC: begin
                res_p0 = sub_diff[31:0];
                c_p0   = sub_diff[32];
                v_p0   = sub_ovf(reg2[31], reg3[31], sub_diff[31]);
            end
            OP_AND:  res_p0 = reg2 & reg3;
            OP_OR:   res_p0 = reg2 | reg3;
            OP_XOR:  res_p0 = reg2 ^ reg3;
            OP_COMP: begin
                c_p0   = sub_diff[32];
                v_p0   = sub_ovf(reg2[31], reg3[31], sub_diff[31]);
            end
            OP_BIT:  res_p0 = reg2;
`ifdef ALU_MULTIPLY_EN
            OP_MULU: res_p0 = mulu_p0;
            OP_MULS: res_p0 = muls_p0;
`endif
            OP_NOT:  res_p0 = ~reg2;
            OP_LSL: begin
                res_p0 = {reg2[30:0], 1'b0};
                c_p0   = reg2[31];
            end
            OP_LSR: begin
                res_p0 = {1'b0, reg2[31:1]};
                c_p0   = reg2[0];
            end
            OP_ASL: begin
                res_p0 = {reg2[30:0], 1'b0};
                c_p0   = reg2[31];
                v_p0   = reg2[31] ^ reg2[30];
            end
            OP_ASR: begin
                res_p0 = {reg2[31], reg2[31:1]};
                c_p0   = reg2[0];
            end
            OP_NEG: begin
                res_p0 = 32'd0 - reg2;
                c_p0   = (reg2 != 32'd0);
                v_p0   = (reg2 == 32'h8000_0000);
            end
            OP_TEST: res_p0 = reg2;
            default: zn_en_p0 = 1'b0;   // unassigned: pass reg2, all flags clear
        endcase

        // Z/N normally follow the result; COMP and BIT report a different value.
        if (op == OP_COMP)
            flag_src_p0 = sub_diff[31:0];
        else if (op == OP_BIT)
            flag_src_p0 = reg2 & reg3;
        else
            flag_src_p0 = res_p0;
    end

    // Stage p1: registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result    <= 32'd0;
            carry_out <= 1'b0;
            zero_out  <= 1'b0;
            neg_out   <= 1'b0;
            over_out  <= 1'b0;
        end else begin
            result    <= res_p0;
            carry_out <= c_p0;
            zero_out  <= zn_en_p0 && (flag_src_p0 == 32'd0);
            neg_out   <= zn_en_p0 && flag_src_p0[31];
            over_out  <= v_p0;
        end
    end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [31:0] reg2 = 32'd0;
    logic [31:0] reg3 = 32'd0;
    logic        carry_in = 1'b0;
    logic [31:0] result;
    logic        carry_out, zero_out, neg_out, over_out;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        c, z, n, v;
    } exp_t;

    exp_t exp_q[$];

    alu dut (
        .clock(clock), .reset(reset), .op(op), .reg2(reg2), .reg3(reg3),
        .carry_in(carry_in), .result(result), .carry_out(carry_out),
        .zero_out(zero_out), .neg_out(neg_out), .over_out(over_out)
    );

    always #5 clock = ~clock;

    function automatic exp_t dut_out();
        return '{result, carry_out, zero_out, neg_out, over_out};
    endfunction

    function automatic logic out_of_range(input longint x);
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    // Reference model: plain wide-integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [4:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input logic ci);
        exp_t   e;
        longint ua, ub, sa, sb, x, sx, cl;
        logic [31:0] f;
        logic   flags_on;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cl = longint'({63'd0, ci});
        e = '0;
        e.r = a;
        flags_on = 1'b1;
        case (o)
            5'h00, 5'h01: begin
                if (o == 5'h00) cl = 0;
                x = ua + ub + cl;  sx = sa + sb + cl;
                e.r = x[31:0]; e.c = (x >= 64'h1_0000_0000); e.v = out_of_range(sx);
            end
            5'h02, 5'h03, 5'h07: begin
                if (o != 5'h03) cl = 0;
                x = ua - ub - cl;  sx = sa - sb - cl;
                if (o != 5'h07) e.r = x[31:0];
                e.c = (x < 0); e.v = out_of_range(sx);
            end
            5'h04: e.r = a & b;
            5'h05: e.r = a | b;
            5'h06: e.r = a ^ b;
            5'h08: e.r = a;
`ifdef ALU_MULTIPLY_EN
            5'h09: begin x = (ua % 65536) * (ub % 65536); e.r = x[31:0]; end
            5'h0A: begin
                x = longint'($signed(a[15:0])) * longint'($signed(b[15:0]));
                e.r = x[31:0];
            end
`endif
            5'h10: e.r = ~a;
            5'h11: begin x = ua * 2; e.r = x[31:0]; e.c = a[31]; end
            5'h12: begin x = ua / 2; e.r = x[31:0]; e.c = a[0]; end
            5'h13: begin x = sa * 2; e.r = x[31:0]; e.c = a[31]; e.v = out_of_range(x); end
            5'h14: begin x = sa >>> 1; e.r = x[31:0]; e.c = a[0]; end
            5'h15: begin x = -sa; e.r = x[31:0]; e.c = (a != 0); e.v = out_of_range(x); end
            5'h16: e.r = a;
            default: flags_on = 1'b0;
        endcase
        if (o == 5'h07) begin x = ua - ub; f = x[31:0]; end
        else if (o == 5'h08) f = a & b;
        else f = e.r;
        e.z = flags_on && (f == 0);
        e.n = flags_on && f[31];
        return e;
    endfunction

    task automatic chk(input string name, input exp_t act, input exp_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got r=%h c%b z%b n%b v%b, want r=%h c%b z%b n%b v%b",
                     name, act.r, act.c, act.z, act.n, act.v,
                     req.r, req.c, req.z, req.n, req.v);
        end
    endtask

    // Model of what was sampled on each active edge out of reset.
    always @(posedge clock)
        if (reset) exp_q.push_back(model(op, reg2, reg3, carry_in));

    // Compare process: every cycle, DUT against model (or reset state).
    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            chk("reset_state", dut_out(), '0);
        end else if (exp_q.size() > 0) begin
            chk("model", dut_out(), exp_q.pop_front());
        end
    end

    // Directed vector with a hand-computed expectation.
    task automatic vec(input string name, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic ci, input logic [31:0] r,
                       input logic c, input logic z, input logic n, input logic v);
        @(negedge clock);
        op = o; reg2 = a; reg3 = b; carry_in = ci;
        @(posedge clock);
        #1 chk(name, dut_out(), '{r, c, z, n, v});
    endtask

    initial begin
        #1 chk("reset_at_t0", dut_out(), '0);
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;

        vec("add_ovf",    5'h00, 32'h4000_0000, 32'h4000_0000, 0, 32'h8000_0000, 0, 0, 1, 1);
        vec("add_wrap",   5'h00, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1, 1, 0, 0);
        vec("addc_wrap",  5'h01, 32'hFFFF_FFFF, 32'h0000_0000, 1, 32'h0000_0000, 1, 1, 0, 0);
        vec("addc_ovf",   5'h01, 32'h7FFF_FFFE, 32'h0000_0001, 1, 32'h8000_0000, 0, 0, 1, 1);
        vec("sub_ovf",    5'h02, 32'h8000_0000, 32'h0000_0001, 0, 32'h7FFF_FFFF, 0, 0, 0, 1);
        vec("subc_brw",   5'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 0, 1, 0);
        vec("subc_ovf",   5'h03, 32'h0000_0000, 32'h8000_0000, 0, 32'h8000_0000, 1, 0, 1, 1);
        vec("comp",       5'h07, 32'h0000_0001, 32'h0000_0002, 0, 32'h0000_0001, 1, 0, 1, 0);
        vec("bit",        5'h08, 32'h0808_0808, 32'h8080_8080, 0, 32'h0808_0808, 0, 1, 0, 0);
        vec("test_zero",  5'h16, 32'h0000_0000, 32'h1234_5678, 1, 32'h0000_0000, 0, 1, 0, 0);
        vec("asl",        5'h13, 32'h8080_8080, 32'h0, 0, 32'h0101_0100, 1, 0, 0, 1);
        vec("asr",        5'h14, 32'h8080_8080, 32'h0, 0, 32'hC040_4040, 0, 0, 1, 0);
        vec("lsr",        5'h12, 32'hFFFF_FFFF, 32'h0, 0, 32'h7FFF_FFFF, 1, 0, 0, 0);
        vec("neg_m1",     5'h15, 32'hFFFF_FFFF, 32'h0, 0, 32'h0000_0001, 1, 0, 0, 0);
        vec("neg_min",    5'h15, 32'h8000_0000, 32'h0, 0, 32'h8000_0000, 1, 0, 1, 1);
        vec("unassigned", 5'h1F, 32'h0000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 0, 0, 0, 0);
`ifdef ALU_MULTIPLY_EN
        vec("mulu_max",   5'h09, 32'h0000_FFFF, 32'h0000_FFFF, 0, 32'hFFFE_0001, 0, 0, 1, 0);
        vec("muls_mix",   5'h0A, 32'h0000_7FFF, 32'h0000_8000, 0, 32'hC000_8000, 0, 0, 1, 0);
        vec("muls_m1",    5'h0A, 32'h0000_FFFF, 32'h0000_FFFF, 0, 32'h0000_0001, 0, 0, 0, 0);
`else
        vec("mulu_off",   5'h09, 32'h0000_0004, 32'h0000_1000, 0, 32'h0000_0004, 0, 0, 0, 0);
        vec("muls_off",   5'h0A, 32'h8000_0000, 32'h0000_0002, 0, 32'h8000_0000, 0, 0, 0, 0);
`endif

        // Sweep every opcode over a few operand pairs; the compare process checks these.
        for (int p = 0; p < 4; p++) begin
            for (int o = 0; o < 32; o++) begin
                @(negedge clock);
                op = o[4:0];
                case (p)
                    0: begin reg2 = 32'h7FFF_FFFF; reg3 = 32'hFFFF_FFFF; carry_in = 1'b1; end
                    1: begin reg2 = 32'h8000_0001; reg3 = 32'h8000_0000; carry_in = 1'b0; end
                    2: begin reg2 = 32'h1234_ABCD; reg3 = 32'h1234_ABCD; carry_in = 1'b1; end
                    default: begin reg2 = $urandom; reg3 = $urandom; carry_in = 1'($urandom); end
                endcase
            end
        end

        // Reset asserted mid-stream with ADD operands held: outputs clear without a clock.
        vec("pre_reset",  5'h00, 32'h0000_0005, 32'h0000_0006, 0, 32'h0000_000B, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1 chk("async_reset", dut_out(), '0);
        @(negedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 chk("post_reset", dut_out(), '{32'h0000_000B, 1'b0, 1'b0, 1'b0, 1'b0});

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
